// File: rtl/flag_unit.sv
// NZCV flag unit: raw flags -> pending register -> architectural nzcv, plus ARM condition decode.
// Optional macro FLAG_BYPASS_EN forwards pending flags to the condition decoder instead of stalling.
module flag_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] cout_out,
  input  logic             in_valid,
  input  logic             set_flags,
  input  logic             flush,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             cond_taken,
  output logic [3:0]       nzcv,
  output logic             pending_valid,
  output logic             stall_req
);

  logic [3:0] raw_flags, sel_flags;
  logic [3:0] pend_q, pend_d, nzcv_q, nzcv_d;
  logic       pend_vld_q, pend_vld_d;
  logic       unused_cout;

  // Only the top two carry bits matter; the rest of the chain is reduced away.
  assign unused_cout = ^cout_out;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = !z;
      4'b0010: eval_cond = cy;
      4'b0011: eval_cond = !cy;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = !n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = !v;
      4'b1000: eval_cond = cy && !z;
      4'b1001: eval_cond = !cy || z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = !z && (n == v);
      4'b1101: eval_cond = z || (n != v);
      default: eval_cond = 1'b1;
    endcase
  endfunction

  always_comb begin
    raw_flags = {result[WIDTH-1], ~|result, cout_out[WIDTH-1],
                 cout_out[WIDTH-1] ^ cout_out[WIDTH-2]};
  end

  // Flush squashes both the incoming and the in-flight update in the same cycle.
  always_comb begin
    pend_vld_d = in_valid && set_flags && !flush;
    pend_d     = pend_vld_d ? raw_flags : pend_q;
    nzcv_d     = (pend_vld_q && !flush) ? pend_q : nzcv_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 4'b0000;
      pend_vld_q <= 1'b0;
      nzcv_q     <= 4'b0000;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      nzcv_q     <= nzcv_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  always_comb begin
    sel_flags = pend_vld_q ? pend_q : nzcv_q;
    stall_req = 1'b0;
  end
`else
  always_comb begin
    sel_flags = nzcv_q;
    stall_req = reset_n && cond_valid && pend_vld_q;
  end
`endif

  always_comb begin
    cond_taken = reset_n && cond_valid && eval_cond(cond, sel_flags);
  end

  assign nzcv          = nzcv_q;
  assign pending_valid = pend_vld_q;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 64, datapath width in bits (legal range 2..128).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: result  input  WIDTH  ALU result.
REQ-005 SHALL have port: cout_out  input  WIDTH  per-bit carry-out chain from the ALU.
REQ-006 SHALL have port: in_valid  input  1  result/cout_out qualify this cycle.
REQ-007 SHALL have port: set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS class).
REQ-008 SHALL have port: flush  input  1  squash the in-flight (pending) flag update.
REQ-009 SHALL have port: cond_valid  input  1  branch-condition query this cycle.
REQ-010 SHALL have port: cond  input  4  ARM condition code.
REQ-011 SHALL have port: cond_taken  output  1  condition evaluates true (combinational).
REQ-012 SHALL have port: nzcv  output  4  architectural flags {N,Z,C,V}.
REQ-013 SHALL have port: pending_valid  output  1  a flag update is in flight.
REQ-014 SHALL have port: stall_req  output  1  query must stall one cycle.

Function
REQ-015 SHALL compute raw flags combinationally: N=result[WIDTH-1]; Z=1 iff all result bits 0; C=cout_out[WIDTH-1]; V=cout_out[WIDTH-1]^cout_out[WIDTH-2].
REQ-016 SHALL, on each rising edge, load the pending register with the raw flags and set pending_valid iff in_valid && set_flags && !flush; otherwise SHALL clear pending_valid.
REQ-017 SHALL, on each rising edge with pending_valid && !flush, copy the pending flags into nzcv; nzcv SHALL otherwise hold.
REQ-018 SHALL therefore have a latency of 1 cycle from a qualifying input to pending_valid and 2 cycles to nzcv.
REQ-019 SHALL support back-to-back setters: the older pending value commits to nzcv while the newer value is captured into pending on the same edge.
REQ-020 SHALL give flush priority over in_valid and commit: an asserted flush discards both the pending value and the incoming value; nzcv holds.
REQ-021 SHALL ignore in_valid without set_flags (no flag change).
REQ-022 SHALL decode cond over the selected flags: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 and 1111 are always 1.
REQ-023 SHALL drive cond_taken=0 whenever cond_valid=0.

Reset
REQ-024 SHALL, while reset_n=0 and independent of clk, force nzcv=4'b0000, clear the pending flags and pending_valid, and hold stall_req=0 and cond_taken=0.
REQ-025 SHALL discard an in-flight update when reset asserts mid-operation; the first edge after deassertion behaves as a normal cycle.

Configuration
REQ-026 SHALL recognise the macro FLAG_BYPASS_EN.
REQ-027 SHALL, with FLAG_BYPASS_EN defined, evaluate cond against the pending flags when pending_valid=1, else against nzcv; stall_req SHALL be constant 0.
REQ-028 SHALL, with FLAG_BYPASS_EN undefined, evaluate cond against nzcv only and drive stall_req = cond_valid && pending_valid.

Verification
REQ-029 SHALL cover: WIDTH=64, result=0, cout_out=0, in_valid=1, set_flags=1 -> pending_valid=1 next cycle; nzcv=0100 two cycles after the input.
REQ-030 SHALL cover: result=64'h8000_0000_0000_0000, cout_out[63:62]=2'b01, set -> nzcv=1001 after 2 cycles; cond=1011 (LT) then evaluates 0, cond=1010 (GE) evaluates 1.
REQ-031 SHALL cover: setter (Z=1) followed next cycle by flush=1 -> pending_valid=0, nzcv unchanged from its prior value.
REQ-032 SHALL cover: setter yielding Z=1, with cond=0000 queried in the next cycle -> with FLAG_BYPASS_EN, cond_taken=1 and stall_req=0; without it, stall_req=1 and cond_taken reflects the old nzcv.
REQ-033 SHALL cover: back-to-back setters producing nzcv 0100 then 1000 -> nzcv=0100 at cycle t+2, 1000 at t+3; reset_n pulsed low at t+1 instead -> nzcv=0000, pending_valid=0 immediately.
REQ-034 SHALL cover: WIDTH=8 sweep of all 16 cond codes against all 16 nzcv values -> cond_taken matches the REQ-022 table.
